// File: rtl/uacm_loopback_fifo_pkg.sv
// Mode encodings and packet-FSM states shared by the loopback buffer and its bench.
package uacm_loopback_fifo_pkg;

  localparam logic [1:0] MODE_STREAM = 2'b00;
  localparam logic [1:0] MODE_PACKET = 2'b01;
  localparam logic [1:0] MODE_SINK   = 2'b10;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FORCE = 2'd2
  } pkt_state_e;

endpackage

// File: rtl/uacm_fifo_mem.sv
// Storage, wrap-bit pointers, full/empty and fill level for the loopback buffer.
// Writes land at the clock edge; read data is combinational at rd_ptr with no empty bypass.
module uacm_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0] mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic           do_push, do_pop;

  // Full: same slot, opposite lap.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign {out_last, out_data} = mem_q[rd_ptr_q[AW-1:0]];
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
  end

endmodule

// File: rtl/uacm_loopback_fifo.sv
// OUT->IN loopback buffer with stream/packet/sink modes and in_flush_now generation.
// Data appears one cycle after push at the earliest; s_ready drops only when full (always high in sink).
module uacm_loopback_fifo
  import uacm_loopback_fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_last,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   flush_now,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);

  pkt_state_e  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic        armed_q, armed_d;
  logic        flush_q, flush_d;
  logic        full, empty, push, pop, sink_mode, pkt_mode, last_pop, timeout_hit;

  assign sink_mode = (mode_q == MODE_SINK);
  assign pkt_mode  = (mode_q == MODE_PACKET);
  assign s_ready   = rst_n & (sink_mode | ~full);
  assign push      = s_valid & s_ready & ~sink_mode;
  assign pop       = m_valid & m_ready;
  assign last_pop  = pop & m_last;
  assign flush_now = flush_q;

  uacm_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .in_data  (s_data),
    .in_last  (s_last),
    .out_data (m_data),
    .out_last (m_last),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_comb begin
    m_valid = 1'b0;
    if (pkt_mode) begin
      if (state_q != ST_WAIT) m_valid = ~empty;
    end else if (!sink_mode) begin
      m_valid = ~empty;
    end
  end

  // Counts stored 'last' markers in every mode so a mode switch never sees a stale count.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if ((push & s_last) && !last_pop)      pkt_cnt_d = pkt_cnt_q + 1'b1;
    else if (!(push & s_last) && last_pop) pkt_cnt_d = pkt_cnt_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (pkt_mode) begin
      case (state_q)
        ST_WAIT: begin
          if (pkt_cnt_q != '0) state_d = ST_SEND;
          else if (full)       state_d = ST_FORCE;
        end
        ST_SEND: begin
          if (last_pop && (pkt_cnt_d == '0)) state_d = ST_WAIT;
        end
        ST_FORCE: begin
          if (last_pop || empty) state_d = ST_WAIT;
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // Mode only changes on a packet boundary with nothing buffered.
  assign mode_d = (empty && (state_q == ST_WAIT)) ? mode : mode_q;

  always_comb begin
    timeout_hit = armed_q & ~pop & (idle_q == TW'(TIMEOUT - 2));
    flush_d     = last_pop | timeout_hit;
    armed_d     = armed_q;
    if (pop && !m_last) armed_d = 1'b1;
    else if (flush_d)   armed_d = 1'b0;
    idle_d = '0;
    if (armed_q && !pop && !timeout_hit) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT;
      mode_q    <= MODE_STREAM;
      pkt_cnt_q <= '0;
      idle_q    <= '0;
      armed_q   <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pkt_cnt_q <= pkt_cnt_d;
      idle_q    <= idle_d;
      armed_q   <= armed_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_uacm_loopback_fifo.sv
// Directed bench for uacm_loopback_fifo (DEPTH=16, TIMEOUT=8).
module tb_uacm_loopback_fifo;
  import uacm_loopback_fifo_pkg::*;

  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [7:0]    s_data = 8'h00;
  logic          s_last = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          flush_now;
  logic [LW-1:0] level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uacm_loopback_fifo #(.WIDTH(8), .DEPTH(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .flush_now(flush_now), .level(level)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    tests++; if (flush_now !== 1'b0) begin fails++; $display("FAIL reset_flush got %b exp 0", flush_now); end
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
    rst_n = 1'b1;
    #1;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_release_s_ready got %b exp 1", s_ready); end
    tick(1);
  endtask

  task automatic test_stream();
    logic [7:0] exp;
    mode = 2'b00; m_ready = 1'b0;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL stream_push_rdy[%0d] got %b exp 1", i, s_ready); end
      s_valid = 1'b1; s_data = 8'(8'h41 + i); s_last = 1'b0;
      tick(1);
    end
    s_valid = 1'b0;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL stream_full_rdy got %b exp 0", s_ready); end
    tests++; if (level !== 5'd16) begin fails++; $display("FAIL stream_full_level got %0d exp 16", level); end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = 8'(8'h41 + i);
      tests++;
      if (m_valid !== 1'b1 || m_data !== exp) begin
        fails++; $display("FAIL stream_out[%0d] got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, exp);
      end
      tick(1);
    end
    m_ready = 1'b0;
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL stream_drain_level got %0d exp 0", level); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL stream_drain_valid got %b exp 0", m_valid); end
  endtask

  task automatic test_timeout();
    int pulses;
    tick(20);
    mode = 2'b00; m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h33; s_last = 1'b0;
    tick(1);
    s_valid = 1'b0;
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL timeout_byte_valid got %b exp 1", m_valid); end
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      if (flush_now === 1'b1) pulses++;
      tests++;
      if (flush_now !== (i == 8)) begin
        fails++; $display("FAIL timeout_pulse[+%0d] got %b exp %b", i, flush_now, (i == 8));
      end
      tick(1);
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL timeout_pulse_count got %0d exp 1", pulses); end
  endtask

  task automatic test_packet();
    tick(20);
    mode = 2'b01; m_ready = 1'b1;
    tick(1);
    tests++; if (dut.mode_q !== MODE_PACKET) begin fails++; $display("FAIL pkt_mode_load got %b exp 01", dut.mode_q); end
    s_valid = 1'b1; s_data = 8'h10; s_last = 1'b0; tick(1);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL pkt_hold0 got %b exp 0", m_valid); end
    s_data = 8'h11; tick(1);
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL pkt_hold1 got %b exp 0", m_valid); end
    s_data = 8'h12; s_last = 1'b1; tick(1);
    s_valid = 1'b0; s_last = 1'b0;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL pkt_hold2 got %b exp 0", m_valid); end
    tick(1);
    tests++; if (m_valid !== 1'b1 || m_data !== 8'h10 || m_last !== 1'b0) begin fails++; $display("FAIL pkt_out0 got v=%b d=%h l=%b exp v=1 d=10 l=0", m_valid, m_data, m_last); end
    tests++; if (flush_now !== 1'b0) begin fails++; $display("FAIL pkt_flush_early0 got %b exp 0", flush_now); end
    tick(1);
    tests++; if (m_valid !== 1'b1 || m_data !== 8'h11 || m_last !== 1'b0) begin fails++; $display("FAIL pkt_out1 got v=%b d=%h l=%b exp v=1 d=11 l=0", m_valid, m_data, m_last); end
    tick(1);
    tests++; if (m_valid !== 1'b1 || m_data !== 8'h12 || m_last !== 1'b1) begin fails++; $display("FAIL pkt_out2 got v=%b d=%h l=%b exp v=1 d=12 l=1", m_valid, m_data, m_last); end
    tests++; if (flush_now !== 1'b0) begin fails++; $display("FAIL pkt_flush_early2 got %b exp 0", flush_now); end
    tick(1);
    tests++; if (flush_now !== 1'b1) begin fails++; $display("FAIL pkt_flush got %b exp 1", flush_now); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL pkt_empty_valid got %b exp 0", m_valid); end
    tick(1);
    tests++; if (flush_now !== 1'b0) begin fails++; $display("FAIL pkt_flush_once got %b exp 0", flush_now); end
    m_ready = 1'b0;
  endtask

  task automatic test_force();
    int k, got;
    logic acc;
    logic [7:0] exp;
    mode = 2'b01; m_ready = 1'b0;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h60 + i); s_last = 1'b0;
      tick(1);
    end
    s_valid = 1'b0;
    tests++; if (m_valid !== 1'b0 || level !== 5'd16) begin fails++; $display("FAIL force_full got v=%b lvl=%0d exp v=0 lvl=16", m_valid, level); end
    tick(1);
    tests++; if (m_valid !== 1'b1 || dut.state_q !== ST_FORCE) begin fails++; $display("FAIL force_enter got v=%b st=%0d exp v=1 st=2", m_valid, dut.state_q); end
    k = 16; got = 0;
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'(8'h60 + k);
    for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
      if (m_valid === 1'b1) begin
        exp = 8'(8'h60 + got);
        tests++;
        if (m_data !== exp || m_last !== 1'b0) begin
          fails++; $display("FAIL force_out[%0d] got d=%h l=%b exp d=%h l=0", got, m_data, m_last, exp);
        end
        got++;
      end
      acc = s_valid & s_ready;
      tick(1);
      if (acc) k++;
      s_valid = (k < 20);
      s_data = 8'(8'h60 + k);
    end
    s_valid = 1'b0; m_ready = 1'b0;
    tests++; if (got != 20) begin fails++; $display("FAIL force_count got %0d exp 20", got); end
    tick(1);
    tests++; if (dut.state_q !== ST_WAIT || level !== 5'd0) begin fails++; $display("FAIL force_exit got st=%0d lvl=%0d exp st=0 lvl=0", dut.state_q, level); end
  endtask

  task automatic test_mode_switch();
    logic [7:0] exp;
    tick(20);
    mode = 2'b00; m_ready = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h80 + i); s_last = 1'b0;
      tick(1);
    end
    s_valid = 1'b0;
    tests++; if (level !== 5'd5) begin fails++; $display("FAIL msw_level got %0d exp 5", level); end
    mode = 2'b10;
    tick(2);
    tests++; if (dut.mode_q !== MODE_STREAM || m_valid !== 1'b1) begin fails++; $display("FAIL msw_hold got mode=%b v=%b exp mode=00 v=1", dut.mode_q, m_valid); end
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp = 8'(8'h80 + i);
      tests++;
      if (m_valid !== 1'b1 || m_data !== exp) begin
        fails++; $display("FAIL msw_out[%0d] got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, exp);
      end
      tick(1);
    end
    m_ready = 1'b0;
    tick(1);
    tests++; if (dut.mode_q !== MODE_SINK) begin fails++; $display("FAIL msw_sink_load got %b exp 10", dut.mode_q); end
    s_valid = 1'b1; s_data = 8'hEE;
    tick(3);
    tests++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || level !== 5'd0) begin fails++; $display("FAIL msw_sink got rdy=%b v=%b lvl=%0d exp rdy=1 v=0 lvl=0", s_ready, m_valid, level); end
    s_valid = 1'b0;
    mode = 2'b00;
    tick(1);
  endtask

  task automatic test_reset_mid();
    int got;
    tick(20);
    mode = 2'b01; m_ready = 1'b0;
    tick(1);
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h90 + i); s_last = 1'b0;
      tick(1);
    end
    s_valid = 1'b0;
    tests++; if (level !== 5'd7) begin fails++; $display("FAIL rst_mid_pre_level got %0d exp 7", level); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (level !== 5'd0 || m_valid !== 1'b0 || flush_now !== 1'b0) begin fails++; $display("FAIL rst_mid_clear got lvl=%0d v=%b f=%b exp 0 0 0", level, m_valid, flush_now); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    tests++; if (flush_now !== 1'b0 || s_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_after got f=%b rdy=%b exp f=0 rdy=1", flush_now, s_ready); end
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'hA0; s_last = 1'b0; tick(1);
    s_data = 8'hA1; s_last = 1'b1; tick(1);
    s_valid = 1'b0; s_last = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 10 && got < 2; cyc++) begin
      if (m_valid === 1'b1) begin
        tests++;
        if (m_data !== 8'(8'hA0 + got) || m_last !== (got == 1)) begin
          fails++; $display("FAIL rst_mid_out[%0d] got d=%h l=%b", got, m_data, m_last);
        end
        got++;
      end
      tick(1);
    end
    m_ready = 1'b0;
    tests++; if (got != 2) begin fails++; $display("FAIL rst_mid_count got %0d exp 2", got); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_timeout();
    test_packet();
    test_force();
    test_mode_switch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
